// File: rtl/ripple_cap_pkg.sv
// Shared types and defaults for the ripple counter capture block.
// Latency: n/a (package). Backpressure: n/a.
package ripple_cap_pkg;

    localparam int DEF_CNT_W      = 3;
    localparam int DEF_EXT_W      = 16;
    localparam int DEF_STABLE_CYC = 2;
    localparam int STAB_W         = 4;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_TRACK = 1'b1
    } cap_state_t;

endpackage

// File: rtl/vec_sync_2ff.sv
// Per-bit two-flop synchronizer for a W-bit vector.
// Latency: 2 clk. Backpressure: none, samples every cycle.
module vec_sync_2ff #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_dat,
    output logic [W-1:0] o_dat
);

    logic [W-1:0] r_s1;
    logic [W-1:0] r_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= i_dat;
            r_s2 <= r_s1;
        end
    end

    assign o_dat = r_s2;

endmodule

// File: rtl/ripple_count_capture.sv
// Syncs and filters a ripple counter, extends it to an EXT_W event count; SKIP_DETECT_EN adds skip_err.
// Latency: outputs update 2+STABLE_CYC clk after cnt_in settles. Backpressure: none, clr has priority.
module ripple_count_capture
    import ripple_cap_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int EXT_W      = DEF_EXT_W,
    parameter int STABLE_CYC = DEF_STABLE_CYC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] cnt_in,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt_sync,
    output logic [EXT_W-1:0] ext_cnt,
    output logic             upd,
    output logic             wrap,
    output logic             ovf,
    output logic             skip_err
);

    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYC);
    localparam logic [STAB_W-1:0] STAB_PRE = STAB_W'(STABLE_CYC - 1);

    logic [CNT_W-1:0] w_s2;
    logic [CNT_W-1:0] r_cand;
    logic [STAB_W-1:0] r_stab;
    logic [1:0]       r_sync_vld;
    logic             w_same;
    logic             w_accept;
    logic [CNT_W-1:0] w_delta;
    logic [EXT_W:0]   w_sum;

    cap_state_t       r_state;
    logic [CNT_W-1:0] r_sync;
    logic [EXT_W-1:0] r_ext;
    logic             r_upd;
    logic             r_wrap;
    logic             r_ovf;

    vec_sync_2ff #(.W(CNT_W)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_dat (cnt_in),
        .o_dat (w_s2)
    );

    // The zeros flushed through the synchronizer by reset are not real samples.
    always_comb begin
        w_same   = (w_s2 == r_cand);
        w_accept = 1'b0;
        if (r_sync_vld[1]) begin
            w_accept = w_same ? (r_stab == STAB_PRE) : (STABLE_CYC == 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cand     <= '0;
            r_stab     <= '0;
            r_sync_vld <= '0;
        end else begin
            r_sync_vld <= {r_sync_vld[0], 1'b1};
            if (clr) begin
                r_stab <= '0;
            end else if (r_sync_vld[1]) begin
                if (!w_same) begin
                    r_cand <= w_s2;
                    r_stab <= STAB_W'(1);
                end else if (r_stab != STAB_MAX) begin
                    r_stab <= r_stab + 1'b1;
                end
            end
        end
    end

    assign w_delta = w_s2 - r_sync;
    assign w_sum   = {1'b0, r_ext} + (EXT_W+1)'(w_delta);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
            r_sync  <= '0;
            r_ext   <= '0;
            r_upd   <= 1'b0;
            r_wrap  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_upd  <= 1'b0;
            r_wrap <= 1'b0;
            if (clr) begin
                r_state <= ST_INIT;
                r_ext   <= '0;
                r_ovf   <= 1'b0;
            end else if (w_accept) begin
                case (r_state)
                    ST_INIT: begin
                        r_sync  <= w_s2;
                        r_state <= ST_TRACK;
                    end
                    ST_TRACK: begin
                        if (w_s2 != r_sync) begin
                            r_ext  <= w_sum[EXT_W-1:0];
                            r_sync <= w_s2;
                            r_upd  <= 1'b1;
                            r_wrap <= (w_s2 < r_sync);
                            if (w_sum[EXT_W]) begin
                                r_ovf <= 1'b1;
                            end
                        end
                    end
                    default: r_state <= ST_INIT;
                endcase
            end
        end
    end

`ifdef SKIP_DETECT_EN
    logic r_skip;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skip <= 1'b0;
        end else if (clr) begin
            r_skip <= 1'b0;
        end else if (w_accept && (r_state == ST_TRACK) && (w_delta > CNT_W'(1))) begin
            r_skip <= 1'b1;
        end
    end

    assign skip_err = r_skip;
`else
    assign skip_err = 1'b0;
`endif

    assign cnt_sync = r_sync;
    assign ext_cnt  = r_ext;
    assign upd      = r_upd;
    assign wrap     = r_wrap;
    assign ovf      = r_ovf;

endmodule

// File: tb/tb_ripple_count_capture.sv
// Directed bench for ripple_count_capture with an input-history reference model.
module tb_ripple_count_capture;

    localparam int CNT_W      = 3;
    localparam int EXT_W      = 4;
    localparam int STABLE_CYC = 2;
    localparam int CNT_MOD    = 1 << CNT_W;
    localparam int EXT_MOD    = 1 << EXT_W;
`ifdef SKIP_DETECT_EN
    localparam int SKIP = 1;
`else
    localparam int SKIP = 0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [CNT_W-1:0] cnt_in;
    logic             clr;
    logic [CNT_W-1:0] cnt_sync;
    logic [EXT_W-1:0] ext_cnt;
    logic             upd;
    logic             wrap;
    logic             ovf;
    logic             skip_err;

    int checks = 0;
    int errors = 0;
    int upd_cnt = 0;
    int wrap_cnt = 0;
    int u0, w0;

    ripple_count_capture #(
        .CNT_W      (CNT_W),
        .EXT_W      (EXT_W),
        .STABLE_CYC (STABLE_CYC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cnt_in   (cnt_in),
        .clr      (clr),
        .cnt_sync (cnt_sync),
        .ext_cnt  (ext_cnt),
        .upd      (upd),
        .wrap     (wrap),
        .ovf      (ovf),
        .skip_err (skip_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int cyc);
        repeat (cyc) @(negedge clk);
        #1;
    endtask

    // Reference model: hist[k] is cnt_in as seen at rising edge k after reset.
    // A sample reaches the filter two edges later; a value is accepted when its
    // run of identical samples (not reaching back past a clr/reset restart) is
    // exactly STABLE_CYC long.
    int hist [0:4095];
    int n = 0, rst_idx = 1;
    int m_sync = 0, m_ext = 0, m_k, m_len, m_v, m_d;
    bit m_init = 1'b1, m_ovf = 1'b0, m_skip = 1'b0, m_upd = 1'b0, m_wrap = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n = 0; rst_idx = 1;
            m_sync = 0; m_ext = 0;
            m_init = 1'b1; m_ovf = 1'b0; m_skip = 1'b0; m_upd = 1'b0; m_wrap = 1'b0;
        end else begin
            if (n < 4095) n++;
            hist[n] = int'(cnt_in);
            m_upd = 1'b0;
            m_wrap = 1'b0;
            if (clr) begin
                m_ext = 0; m_ovf = 1'b0; m_skip = 1'b0; m_init = 1'b1;
                rst_idx = (n - 1 < 1) ? 1 : n - 1;
            end else if (n - 2 >= rst_idx) begin
                m_k = n - 2;
                m_len = 1;
                while (m_k - 1 >= rst_idx && hist[m_k-1] == hist[m_k] && m_len <= STABLE_CYC) begin
                    m_len++;
                    m_k--;
                end
                if (m_len == STABLE_CYC) begin
                    m_v = hist[n-2];
                    if (m_init) begin
                        m_sync = m_v;
                        m_init = 1'b0;
                    end else if (m_v != m_sync) begin
                        m_d = (m_v - m_sync + CNT_MOD) % CNT_MOD;
                        m_wrap = (m_v < m_sync);
                        m_upd = 1'b1;
                        m_ext = m_ext + m_d;
                        if (m_ext >= EXT_MOD) begin
                            m_ext = m_ext - EXT_MOD;
                            m_ovf = 1'b1;
                        end
                        if (SKIP != 0 && m_d > 1) m_skip = 1'b1;
                        m_sync = m_v;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("cnt_sync", int'(cnt_sync), m_sync);
        chk("ext_cnt", int'(ext_cnt), m_ext);
        chk("upd", int'(upd), int'(m_upd));
        chk("wrap", int'(wrap), int'(m_wrap));
        chk("ovf", int'(ovf), int'(m_ovf));
        chk("skip_err", int'(skip_err), int'(m_skip));
        if (upd) upd_cnt++;
        if (wrap) wrap_cnt++;
    end

    initial begin
        rst_n = 1'b0;
        cnt_in = 3'd3;
        clr = 1'b0;
        tick(3);
        rst_n = 1'b1;

        // Baseline latency: nothing before edge 4, value 3 at edge 4.
        tick(3);
        chk("lat_edge3_sync", int'(cnt_sync), 0);
        tick(1);
        chk("lat_edge4_sync", int'(cnt_sync), 3);
        chk("base_ext", int'(ext_cnt), 0);
        chk("base_upd", int'(upd), 0);

        // Steps 4,5,6,7,0 from baseline 3.
        u0 = upd_cnt; w0 = wrap_cnt;
        for (int i = 0; i < 5; i++) begin
            cnt_in = 3'((4 + i) % 8);
            tick(6);
        end
        chk("steps_upd", upd_cnt - u0, 5);
        chk("steps_wrap", wrap_cnt - w0, 1);
        chk("steps_ext", int'(ext_cnt), 5);
        chk("steps_sync", int'(cnt_sync), 0);

        // Glitch: 3 held one cycle is filtered out.
        cnt_in = 3'd1;
        tick(6);
        u0 = upd_cnt;
        cnt_in = 3'd3;
        tick(1);
        cnt_in = 3'd2;
        tick(6);
        chk("glitch_upd", upd_cnt - u0, 1);
        chk("glitch_ext", int'(ext_cnt), 7);
        chk("glitch_sync", int'(cnt_sync), 2);

        // Multi-count jumps: 2->6 (delta 4), 6->1 (delta 3, wraps).
        cnt_in = 3'd6;
        tick(6);
        chk("jump_ext", int'(ext_cnt), 11);
        w0 = wrap_cnt;
        cnt_in = 3'd1;
        tick(6);
        chk("skip_ext", int'(ext_cnt), 14);
        chk("skip_wrap", wrap_cnt - w0, 1);
        chk("skip_flag", int'(skip_err), SKIP);

        // 14 + 3 overflows the 4-bit accumulator.
        cnt_in = 3'd4;
        tick(6);
        chk("ovf_ext", int'(ext_cnt), 1);
        chk("ovf_flag", int'(ovf), 1);

        // clr, then the new value 5 loads as baseline without an update.
        cnt_in = 3'd5;
        tick(1);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("clr_ext", int'(ext_cnt), 0);
        chk("clr_ovf", int'(ovf), 0);
        chk("clr_skip", int'(skip_err), 0);
        u0 = upd_cnt;
        tick(6);
        chk("rebase_sync", int'(cnt_sync), 5);
        chk("rebase_upd", upd_cnt - u0, 0);
        chk("rebase_ext", int'(ext_cnt), 0);

        // clr on the same edge as the acceptance of 7.
        u0 = upd_cnt;
        cnt_in = 3'd7;
        tick(3);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("clracc_upd", upd_cnt - u0, 0);
        chk("clracc_sync", int'(cnt_sync), 5);
        tick(6);
        chk("clracc_base", int'(cnt_sync), 7);
        chk("clracc_ext", int'(ext_cnt), 0);
        chk("clracc_upd2", upd_cnt - u0, 0);

        // Input toggling every cycle is never accepted.
        u0 = upd_cnt;
        for (int i = 0; i < 10; i++) begin
            cnt_in = (i % 2 == 0) ? 3'd1 : 3'd2;
            tick(1);
        end
        chk("toggle_upd", upd_cnt - u0, 0);
        chk("toggle_sync", int'(cnt_sync), 7);

        // Reset asserted one edge before an acceptance would register.
        tick(6);
        cnt_in = 3'd3;
        tick(3);
        rst_n = 1'b0;
        #1;
        chk("rst_sync", int'(cnt_sync), 0);
        chk("rst_ext", int'(ext_cnt), 0);
        chk("rst_upd", int'(upd), 0);
        chk("rst_wrap", int'(wrap), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_skip", int'(skip_err), 0);
        tick(2);
        rst_n = 1'b1;
        tick(6);
        chk("post_rst_sync", int'(cnt_sync), 3);
        chk("post_rst_ext", int'(ext_cnt), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ripple_count_capture.md
Name: ripple_count_capture

Overview:
Downstream consumer of the 3-bit asynchronous ripple up-counter. Brings the ripple output into the system clock domain and filters out the transient codes produced while the ripple settles. Extends the narrow count into a wide accumulated event count and reports updates and wrap-arounds as single-cycle pulses. Sits between the ripple counter output and any synchronous logic that reads the count.

Parameters:
CNT_W, 3, width of the ripple counter value sampled on cnt_in
EXT_W, 16, width of the extended accumulated count ext_cnt
STABLE_CYC, 2, consecutive identical synchronized samples required before a value is accepted (legal range 1..15)

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst_n  input  1  asynchronous active-low reset
cnt_in  input  CNT_W  raw ripple counter output, asynchronous to clk
clr  input  1  synchronous clear of the accumulated state; one-cycle pulse or level
cnt_sync  output  CNT_W  last accepted (stable) counter value
ext_cnt  output  EXT_W  accumulated count, modulo 2^EXT_W
upd  output  1  one-cycle pulse when an accepted value differs from the previous one
wrap  output  1  one-cycle pulse when an accepted update crosses the counter's maximum code back through 0
ovf  output  1  sticky flag, set when ext_cnt carries out of EXT_W
skip_err  output  1  sticky flag for a missed count; present only with the optional feature

Behaviour:
- Reset (rst_n low, asynchronous): every output is 0. The synchronizer flops, candidate register and stability counter are 0. The FSM enters INIT.
- Synchronizer: a 2-flop chain per bit, s1 then s2. Per-bit synchronization is intentional; multi-bit skew is removed by the stability filter.
- Stability filter:
  - The candidate register holds the last s2 value.
  - If s2 equals the candidate, stab_cnt increments, saturating at STABLE_CYC.
  - If s2 differs, the candidate loads s2 and stab_cnt is set to 1.
  - A value is accepted in the cycle stab_cnt reaches STABLE_CYC. Acceptance fires once per stable run.
- FSM states:
  - INIT: the first accepted value loads cnt_sync as the baseline. ext_cnt is unchanged, upd and wrap stay 0. Transition to TRACK.
  - TRACK: each accepted value V is compared with cnt_sync.
    - If V differs: delta = (V − cnt_sync) mod 2^CNT_W. ext_cnt += delta. cnt_sync <= V. upd pulses.
    - wrap pulses if V < cnt_sync numerically.
    - ovf sets if the ext_cnt addition carries out.
    - If V equals cnt_sync: nothing happens.
- Latency: cnt_in is settled before rising edge 1 and held. s2 is valid at edge 2. With STABLE_CYC=2, acceptance happens at edge 3 and the outputs and pulses are registered at edge 4. In general, outputs update at edge 2+STABLE_CYC.
- upd and wrap are high for exactly one cycle per accepted update.
- clr: synchronous. Zeroes ext_cnt, ovf, skip_err, upd and wrap, restarts the filter (stab_cnt=0) and returns the FSM to INIT. cnt_sync holds its value until the next baseline load. clr has priority over a simultaneous acceptance; that update is discarded.
- A cnt_in that toggles every cycle never gets accepted, so no outputs change.
- ext_cnt wraps modulo 2^EXT_W and keeps counting. ovf stays set until clr or reset.
- Reset asserted mid-update: all state is cleared immediately, with no partial update.

Optional Feature:
Macro SKIP_DETECT_EN.
- Defined: in TRACK, an accepted update with delta > 1 sets sticky skip_err, meaning the ripple counter advanced more than once between accepted samples. The accumulation still adds the full delta. skip_err is cleared only by clr or reset.
- Undefined: skip_err is tied to 0 and the compare logic is absent; all other behaviour is identical.

Decomposition:
- Package ripple_cap_pkg holds:
  - the FSM state typedef (INIT, TRACK);
  - default parameter constants;
  - the stability counter width constant, 4 bits.
- One sub-module, vec_sync_2ff: a parameterized-width 2-flop synchronizer with asynchronous active-low reset. All other logic stays in the top level.

Test Plan:
- Reset release, then cnt_in=3 held -> baseline accepted at edge 4 with cnt_sync=3; ext_cnt=0, upd=0, wrap=0.
- From baseline 3, cnt_in steps 4,5,6,7,0, each held 6 cycles -> five upd pulses; ext_cnt=5 and cnt_sync=0 at the end; one wrap pulse on the 7->0 step.
- Glitch: cnt_in 1->3->2 with 3 held for only 1 cycle, STABLE_CYC=2 -> 3 never accepted; single update 1->2 with ext_cnt +1.
- From baseline 6, jump to 1 -> delta=3, ext_cnt +3, wrap=1. With SKIP_DETECT_EN, skip_err=1; without it, skip_err=0.
- EXT_W=4, ext_cnt=14, accept delta 3 -> ext_cnt=1, ovf=1. Then clr -> ext_cnt=0, ovf=0, FSM in INIT, and the next stable value loads the baseline without an upd pulse.
- clr in the same cycle as an acceptance -> update discarded, ext_cnt=0, no upd; rst_n pulsed low mid-run -> all outputs 0 immediately.
